// File: rtl/des_dec_keysched.sv
// DES key schedule generator: streams the 16 round subkeys for one key.
// REV_ORDER=1 emits K16..K1 (decrypt order), REV_ORDER=0 emits K1..K16.
// Optional build macro DES_KEY_PARITY_CHK_EN: odd-parity check of every key
// byte at acceptance; failing keys raise parity_err and are not loaded.
module des_dec_keysched #(
    parameter int REV_ORDER = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [1:64] key,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [1:48] subkey,
    output logic [4:0]  round,
    output logic        sk_last,
    output logic        parity_err
);

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam logic [4:0] FIRST_RND = (REV_ORDER != 0) ? 5'd16 : 5'd1;
    localparam logic [4:0] LAST_RND  = (REV_ORDER != 0) ? 5'd1  : 5'd16;

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q, state_d;
    logic [1:56] cd_q, cd_d;      // C in [1:28], D in [29:56], DES bit numbering
    logic [4:0]  round_q, round_d;
    logic [1:56] key_pc1;
    logic        par_ok;
    logic        key_ok;

    // Left rotate of one 28-bit half; bit 1 is the MSB so '<<' moves toward bit 1.
    function automatic logic [1:28] rotl28(input logic [1:28] x, input int n);
        return (x << n) | (x >> (28 - n));
    endfunction

    // Rotate both halves independently so no bit crosses the C/D boundary.
    function automatic logic [1:56] rotl_cd(input logic [1:56] x, input int n);
        return {rotl28(x[1:28], n), rotl28(x[29:56], n)};
    endfunction

    function automatic int shamt(input logic [4:0] r);
        case (r)
            5'd1, 5'd2, 5'd9, 5'd16: return 1;
            default:                 return 2;
        endcase
    endfunction

    // PC-1 selection and per-byte odd-parity test of the offered key.
    always_comb begin
        key_pc1 = '0;
        for (int i = 0; i < 56; i++) key_pc1[i+1] = key[PC1[i]];
        par_ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (!(^key[b*8+1 +: 8])) par_ok = 1'b0;
        end
    end

    // PC-2 of the registered halves only; no path from key or sk_ready.
    always_comb begin
        subkey = '0;
        for (int j = 0; j < 48; j++) subkey[j+1] = cd_q[PC2[j]];
    end

`ifdef DES_KEY_PARITY_CHK_EN
    logic perr_q;

    assign key_ok = par_ok;

    // Parity flag is re-evaluated at every key acceptance attempt in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                perr_q <= 1'b0;
        else if (key_valid && state_q == IDLE)  perr_q <= !par_ok;
    end

    assign parity_err = perr_q;
`else
    logic unused_par_ok;

    assign key_ok        = 1'b1;
    assign unused_par_ok = par_ok;
    assign parity_err    = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cd_q    <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            round_q <= round_d;
        end
    end

    // Next state: load on accepted key, step one round per consumed subkey.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (key_valid && key_ok) begin
                    state_d = RUN;
                    round_d = FIRST_RND;
                    // K16 uses C0/D0 (28 total shifts); K1 needs one left shift.
                    cd_d    = (REV_ORDER != 0) ? key_pc1 : rotl_cd(key_pc1, 1);
                end
            end
            RUN: begin
                if (sk_ready) begin
                    if (round_q == LAST_RND) begin
                        state_d = IDLE;
                    end else if (REV_ORDER != 0) begin
                        cd_d    = rotl_cd(cd_q, 28 - shamt(round_q));
                        round_d = round_q - 5'd1;
                    end else begin
                        cd_d    = rotl_cd(cd_q, shamt(round_q + 5'd1));
                        round_d = round_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        key_ready = (state_q == IDLE);
        sk_valid  = (state_q == RUN);
        sk_last   = (state_q == RUN) && (round_q == LAST_RND);
        round     = round_q;
    end

endmodule

// File: doc/des_dec_keysched.md
DES_DEC_KEYSCHED -- requirements
Module: des_dec_keysched

Interface
REQ-001 SHALL have parameter REV_ORDER, default 1: 1 emits subkeys K16..K1 (decrypt order), 0 emits K1..K16 (encrypt order).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port key_valid  input  1  key offered.
REQ-005 SHALL have port key_ready  output  1  block can accept a key.
REQ-006 SHALL have port key  input  [1:64]  DES key, bit 1 = MSB, parity bits 8,16,...,64.
REQ-007 SHALL have port sk_valid  output  1  subkey presented.
REQ-008 SHALL have port sk_ready  input  1  consumer accepts subkey.
REQ-009 SHALL have port subkey  output  [1:48]  PC-2 of current C/D.
REQ-010 SHALL have port round  output  [4:0]  DES round index of subkey (1..16).
REQ-011 SHALL have port sk_last  output  1  high with final subkey of the set.
REQ-012 SHALL have port parity_err  output  1  key parity fault flag.

Function
REQ-013 SHALL implement states IDLE and RUN; key_ready = (state==IDLE); sk_valid = (state==RUN).
REQ-014 IDLE: on key_valid && key_ready, SHALL register C/D = PC-1(key), or rotl(PC-1(key),1) each half when REV_ORDER=0, and enter RUN next cycle.
REQ-015 First subkey SHALL appear on the cycle after key acceptance: K16 (round=16) for REV_ORDER=1, K1 (round=1) for REV_ORDER=0.
REQ-016 Each sk_valid && sk_ready handshake SHALL advance one round: REV_ORDER=1 rotates C and D right by shift[round] and decrements round; REV_ORDER=0 rotates left by shift[round+1] and increments round; shift[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-017 C/D rotations SHALL wrap within each independent 28-bit half.
REQ-018 sk_last SHALL equal sk_valid && (round==1 for REV_ORDER=1, round==16 for REV_ORDER=0).
REQ-019 Handshake on sk_last SHALL return to IDLE, so key_ready is high the next cycle; a new key is never accepted in the same cycle as the last subkey.
REQ-020 While sk_valid && !sk_ready, subkey, round and sk_last SHALL hold stable.
REQ-021 key_valid during RUN SHALL be ignored, with no effect on C/D.
REQ-022 Throughput SHALL be one subkey per cycle with sk_ready held high: 16 subkeys in 16 consecutive cycles.
REQ-023 subkey SHALL be combinational PC-2 of registered C/D only, with no path from key or sk_ready.

Reset
REQ-024 rst SHALL force IDLE immediately, independent of clk, including mid-RUN.
REQ-025 Reset values SHALL be key_ready=1, sk_valid=0, sk_last=0, parity_err=0, round=0, subkey=PC-2(0)=0, C/D=0.
REQ-026 After rst deasserts, the first rising edge with key_valid=1 SHALL accept a key.

Configuration
REQ-027 Macro DES_KEY_PARITY_CHK_EN SHALL compile in odd-parity checking of each key byte at acceptance.
REQ-028 With the macro defined, a parity-failing key SHALL set parity_err (held until the next key acceptance or rst), emit no subkeys, and leave the block in IDLE.
REQ-029 With the macro defined, a passing key SHALL clear parity_err and run normally.
REQ-030 Without the macro, parity_err SHALL be tied 0 and parity bits SHALL be ignored, as PC-1 already drops them; the port list is identical in both builds.

Verification
REQ-031 REV_ORDER=1, key=133457799BBCDFF1, sk_ready=1 -> K16=CB3D8B0E17F5 one cycle after accept, K1=1B02EFFC7072 15 cycles later with sk_last=1, then key_ready=1.
REQ-032 REV_ORDER=0, same key -> first subkey 1B02EFFC7072 with round=1, and the 16th subkey CB3D8B0E17F5 with round=16 and sk_last=1.
REQ-033 Backpressure: sk_ready=0 for 5 cycles at round=9 -> subkey/round stable throughout; the remaining sequence matches REQ-031 values.
REQ-034 rst pulse at round=7 (mid-RUN, between clock edges) -> sk_valid=0 immediately; a new key accepted after release restarts at K16.
REQ-035 DES_KEY_PARITY_CHK_EN defined, key=133457799BBCDFF0 -> parity_err=1, sk_valid stays 0; then key=133457799BBCDFF1 -> parity_err=0 and sequence per REQ-031.
REQ-036 key_valid held high throughout RUN with a different key -> subkey sequence unchanged; the second key is accepted on the cycle after sk_last.
